serial_rx_ram_writer: RTL and testbench



---
 rtl/serial_rx_ram_writer_if.sv | 37 +++
 rtl/serial_rx_ram_writer.sv | 147 ++++++++++++++
 tb/tb_serial_rx_ram_writer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_ram_writer_if.sv
// Bundle of the serial receiver's line input, RAM read port and status outputs.
// Strobe semantics: write_enable, received_n (active low), shift_enable,
// tc_bit and frame_err are one-cycle pulses with no back-pressure. There is
// no ready signal; a consumer must sample them in the cycle they are asserted.
interface serial_rx_ram_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  transmit_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] received_data;
  logic                  received_n;
  logic                  shift_enable;
  logic                  tc_bit;
  logic [3:0]            Q;
  logic                  busy;
  logic                  frame_err;
  logic                  full;

  // Drives the serial line and the read address, observes everything else.
  modport master (
    output transmit_data, rd_addr,
    input  rd_data, ram_addr, ram_data, write_enable, received_data,
           received_n, shift_enable, tc_bit, Q, busy, frame_err, full
  );

  // The receiver itself.
  modport slave (
    input  transmit_data, rd_addr,
    output rd_data, ram_addr, ram_data, write_enable, received_data,
           received_n, shift_enable, tc_bit, Q, busy, frame_err, full
  );
endinterface

// File: rtl/serial_rx_ram_writer.sv
// Serial receiver: finds a start bit, samples DATA_WIDTH bits LSB-first at
// mid-bit, checks the stop bit and stores each good word into an internal RAM
// at an auto-incrementing address. o_state exposes the FSM for checkers.
module serial_rx_ram_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_rx_ram_writer_if.slave bus,
  output logic [2:0]           o_state
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WRITE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [3:0]            r_q, w_q_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_recv, w_recv_nxt;
  logic                  r_full, w_full_nxt;
  logic                  r_se, w_se_nxt;
  logic                  r_tc, w_tc_nxt;
  logic                  r_fe, w_fe_nxt;
  logic                  r_we, r_busy;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Next state and next values of every register; counter free-runs outside IDLE.
  always_comb begin
    w_shifted   = (r_shift >> 1) | (DATA_WIDTH'(bus.transmit_data) << (DATA_WIDTH - 1));
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_q_nxt     = r_q;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_recv_nxt  = r_recv;
    w_full_nxt  = r_full;
    w_se_nxt    = 1'b0;
    w_tc_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!bus.transmit_data) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!bus.transmit_data) begin
            w_state_nxt = S_DATA;
            w_q_nxt     = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = w_shifted;
          w_se_nxt    = 1'b1;
          w_q_nxt     = r_q + 4'd1;
          if (r_q == LAST_BIT) begin
            w_tc_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (bus.transmit_data) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_fe_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        w_recv_nxt  = r_shift;
        w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
        if (r_addr == '1) w_full_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; every output except rd_data is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_shift <= '0;
      r_addr  <= '0;
      r_recv  <= '0;
      r_full  <= 1'b0;
      r_se    <= 1'b0;
      r_tc    <= 1'b0;
      r_fe    <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_shift <= w_shift_nxt;
      r_addr  <= w_addr_nxt;
      r_recv  <= w_recv_nxt;
      r_full  <= w_full_nxt;
      r_se    <= w_se_nxt;
      r_tc    <= w_tc_nxt;
      r_fe    <= w_fe_nxt;
      r_we    <= (w_state_nxt == S_WRITE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Word RAM: written during the single WRITE cycle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_WRITE) r_mem[r_addr] <= r_shift;
  end

  assign bus.rd_data       = r_mem[bus.rd_addr];
  assign bus.ram_addr      = r_addr;
  assign bus.ram_data      = r_shift;
  assign bus.write_enable  = r_we;
  assign bus.received_data = r_recv;
  assign bus.received_n    = ~r_we;
  assign bus.shift_enable  = r_se;
  assign bus.tc_bit        = r_tc;
  assign bus.Q             = r_q;
  assign bus.busy          = r_busy;
  assign bus.frame_err     = r_fe;
  assign bus.full          = r_full;
  assign o_state           = r_state;
endmodule

// File: tb/tb_serial_rx_ram_writer.sv
// Bench for serial_rx_ram_writer: frames are scheduled as expected events per
// clock cycle from the line timing, and a per-cycle compare process checks the
// strobes, status and RAM read port against a word-level model.
module tb_serial_rx_ram_writer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int C  = 4;
  localparam int H  = C / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         cyc = 0;

  serial_rx_ram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  serial_rx_ram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // Clock and cycle counter (cyc = number of rising edges so far).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle events, keyed by cycle number.
  bit          exp_se[int];
  bit          exp_tc[int];
  bit          exp_we[int];
  bit          exp_fe[int];
  bit          exp_busy[int];
  int          exp_qv[int];
  logic [DW-1:0] exp_q[$];

  // Word-level model of the RAM side.
  int            m_addr;
  bit            m_full;
  logic [DW-1:0] m_recv;
  logic [DW-1:0] m_mem [1<<AW];
  bit            m_valid [1<<AW];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit rd_rand  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Random read address whenever the main flow is not sweeping.
  always @(negedge clk) if (rd_rand) bus.rd_addr = AW'($urandom_range(0, (1<<AW) - 1));

  // Per-cycle compare, one time unit after each rising edge.
  initial begin
    bit we_e;
    logic [DW-1:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        we_e = exp_we.exists(cyc);
        chk("shift_enable", bus.shift_enable, exp_se.exists(cyc));
        chk("tc_bit", bus.tc_bit, exp_tc.exists(cyc));
        chk("write_enable", bus.write_enable, we_e);
        chk("received_n", bus.received_n, !we_e);
        chk("frame_err", bus.frame_err, exp_fe.exists(cyc));
        chk("busy", bus.busy, exp_busy.exists(cyc));
        if (exp_se.exists(cyc)) chk("Q", bus.Q, exp_qv[cyc]);
        chk("ram_addr", bus.ram_addr, m_addr);
        chk("received_data", bus.received_data, m_recv);
        chk("full", bus.full, m_full);
        if (m_valid[bus.rd_addr]) chk("rd_data", bus.rd_data, m_mem[bus.rd_addr]);
        if (we_e && exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("ram_data_at_write", bus.ram_data, w);
          m_mem[m_addr]   = w;
          m_valid[m_addr] = 1'b1;
          m_recv          = w;
          if (m_addr == (1<<AW) - 1) m_full = 1'b1;
          m_addr = (m_addr + 1) % (1<<AW);
        end
      end
    end
  end

  // Drive one frame starting at the next rising edge; nbits bit periods are
  // sent (DW+2 for a whole frame). Called and returns at a falling edge.
  task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input int nbits);
    int t0, ts;
    logic [DW+1:0] bits;
    t0 = cyc + 1;
    ts = t0 + H + (DW + 1) * C;
    for (int k = 1; k <= DW; k++) begin
      exp_se[t0 + H + k * C] = 1'b1;
      exp_qv[t0 + H + k * C] = k;
    end
    exp_tc[t0 + H + DW * C] = 1'b1;
    for (int c = t0; c < ts; c++) exp_busy[c] = 1'b1;
    if (stop_ok) begin
      exp_busy[ts] = 1'b1;
      exp_we[ts]   = 1'b1;
      exp_q.push_back(d);
    end else begin
      exp_fe[ts] = 1'b1;
      // The still-low stop bit looks like a new start edge to the idle receiver;
      // its mid-bit re-sample falls after the line is released, so it aborts.
      for (int c = ts + 1; c <= ts + H; c++) exp_busy[c] = 1'b1;
    end
    bits = {stop_ok, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      bus.transmit_data = bits[b];
      repeat (C) @(negedge clk);
    end
    bus.transmit_data = 1'b1;
  endtask

  // Hold the line low for a single cycle.
  task automatic send_glitch();
    int t0;
    t0 = cyc + 1;
    exp_busy[t0]     = 1'b1;
    exp_busy[t0 + 1] = 1'b1;
    bus.transmit_data = 1'b0;
    @(negedge clk);
    bus.transmit_data = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for n cycles, clear schedules and the word model (RAM image kept).
  task automatic do_reset(input int n);
    chk_en = 1'b0;
    rst = 1'b1;
    bus.transmit_data = 1'b1;
    repeat (n) @(negedge clk);
    exp_se.delete(); exp_tc.delete(); exp_we.delete(); exp_fe.delete();
    exp_busy.delete(); exp_qv.delete(); exp_q.delete();
    m_addr = 0; m_full = 1'b0; m_recv = '0;
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_data", bus.ram_data, 0);
    chk("rst_received_data", bus.received_data, 0);
    chk("rst_Q", bus.Q, 0);
    chk("rst_we_se_tc_busy_fe_full",
        {bus.write_enable, bus.shift_enable, bus.tc_bit, bus.busy, bus.frame_err, bus.full}, 0);
    chk("rst_received_n", bus.received_n, 1);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic peek(input int a, input logic [DW-1:0] exp, input string name);
    bus.rd_addr = AW'(a);
    #2;
    chk(name, bus.rd_data, exp);
  endtask

  // Watchdog: the flow is fixed-length, this only guards against a hang.
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    bit ok;
    bus.transmit_data = 1'b1;
    bus.rd_addr = '0;
    rst = 1'b1;
    for (int i = 0; i < (1<<AW); i++) m_valid[i] = 1'b0;
    @(negedge clk);
    do_reset(2);
    idle(3);

    // Half a frame of 0x5A, then a mid-frame reset, then a whole 0x5A.
    send_frame(8'h5A, 1'b1, 5);
    do_reset(2);
    idle(2);
    send_frame(8'h5A, 1'b1, DW + 2);
    idle(4);
    rd_rand = 1'b0;
    @(negedge clk);
    peek(0, 8'h5A, "t1_mem0");
    chk("t1_ram_addr", bus.ram_addr, 1);
    rd_rand = 1'b1;

    // 0xA5 after a fresh reset.
    do_reset(2);
    idle(2);
    send_frame(8'hA5, 1'b1, DW + 2);
    idle(4);
    chk("t2_received_data", bus.received_data, 8'hA5);
    chk("t2_ram_addr", bus.ram_addr, 1);
    chk("t2_Q", bus.Q, 8);

    // Start-bit glitch: no effect.
    send_glitch();
    idle(5);
    chk("t3_ram_addr", bus.ram_addr, 1);
    chk("t3_busy", bus.busy, 0);

    // Bad stop bit, then the same word correctly.
    send_frame(8'h3C, 1'b0, DW + 2);
    idle(6);
    chk("t4_ram_addr_after_err", bus.ram_addr, 1);
    send_frame(8'h3C, 1'b1, DW + 2);
    idle(4);
    chk("t4_ram_addr", bus.ram_addr, 2);
    rd_rand = 1'b0;
    @(negedge clk);
    peek(1, 8'h3C, "t4_mem1");
    rd_rand = 1'b1;

    // Sixteen back-to-back frames fill the RAM, a seventeenth wraps.
    do_reset(2);
    idle(2);
    for (int i = 0; i < 16; i++) send_frame(DW'(i), 1'b1, DW + 2);
    idle(3);
    chk("t5_full", bus.full, 1);
    chk("t5_ram_addr_wrapped", bus.ram_addr, 0);
    send_frame(8'hFF, 1'b1, DW + 2);
    idle(3);
    chk("t5_full_sticky", bus.full, 1);
    chk("t5_ram_addr", bus.ram_addr, 1);

    // Read-port sweep against the transmitted image.
    rd_rand = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) peek(i, (i == 0) ? 8'hFF : DW'(i), "t6_sweep");
    rd_rand = 1'b1;
    @(negedge clk);

    // Randomized traffic: random words, occasional bad stop bits and glitches.
    for (int n = 0; n < 40; n++) begin
      d  = DW'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) begin
        send_glitch();
        idle(4);
      end
      send_frame(d, ok, DW + 2);
      if (ok) idle($urandom_range(0, 3));
      else    idle(H + 2 + $urandom_range(0, 3));
    end
    idle(6);
    chk("final_exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
